conv_mac_controller: RTL and testbench
======================================

Name: conv_mac_controller

Overview:
Sequencer for one convolution layer built around the shared combinational 4x4-bit multiplier.
- Walks a square IMG_W x IMG_W image with a square FLT_W x FLT_W filter, stride 1, no padding.
- Fetches image and filter taps from synchronous-read memories, gates the multiplier via its Start input, and accumulates nine products per output pixel.
- Emits one result per output pixel, then pulses done.

Parameters:
IMG_W, 4, image width/height in pixels
FLT_W, 3, filter width/height in taps
DW, 4, pixel/weight width (multiplier operand width)
PW, 8, product width (2*DW)
ACC_W, 12, accumulator/result width; must hold FLT_W*FLT_W*(2^DW-1)^2 (2025 for defaults)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE
busy  out  1  high from the edge accepting start through the DONE cycle
done  out  1  one-cycle pulse after the last result
mem_re  out  1  read enable for image and filter memories
img_addr  out  clog2(IMG_W*IMG_W)  image read address, row-major
img_rdata  in  DW  image data, valid one cycle after address
flt_addr  out  clog2(FLT_W*FLT_W)  filter read address, row-major
flt_rdata  in  DW  filter data, valid one cycle after address
mul_start  out  1  multiplier Start
mul_a  out  DW  multiplier din0 (= img_rdata, combinational)
mul_b  out  DW  multiplier din1 (= flt_rdata, combinational)
mul_p  in  PW  multiplier dout
out_valid  out  1  one-cycle result strobe
out_addr  out  clog2(OUT_W*OUT_W)  output pixel index r*OUT_W+c, with OUT_W=IMG_W-FLT_W+1
out_data  out  ACC_W  convolution sum

Behaviour:
- **Reset (rst_n low, asynchronous, any state):**
  - State goes to IDLE; all counters and the accumulator clear.
  - busy, done, mem_re, mul_start, out_valid, img_addr, flt_addr, out_addr and out_data all read 0.
  - No partial result is emitted after reset is released.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - start=1 at a clock edge moves to RUN.
  - Output row/col are set to 0, tap counter t=0 and acc=0.
- **RUN (FLT_W*FLT_W cycles per pixel):**
  - mem_re=1.
  - img_addr=(row+t/FLT_W)*IMG_W+(col+t%FLT_W) and flt_addr=t, both registered.
  - t advances 0..FLT_W*FLT_W-1; after the last tap, go to DRAIN.
- **Data pipeline:**
  - A 1-bit valid follows each issued address by one cycle.
  - mul_start equals that valid: low in the first RUN cycle of a pixel, high in the rest of RUN and in DRAIN.
  - While valid, acc <= acc + zero-extended mul_p.
  - When mul_start=0, mul_p is 0 and the accumulate is harmless.
- **DRAIN (1 cycle):**
  - mem_re=0; the last product is accumulated.
  - On the same edge: out_data <= acc+mul_p, out_addr <= row*OUT_W+col, out_valid <= 1 for exactly one cycle.
  - acc clears; col advances, wrapping to 0 with row+1.
  - If more pixels remain, go to RUN with t=0. After pixel OUT_W*OUT_W-1, go to DONE.
- **DONE (1 cycle):** done=1 and busy=1; the final out_valid coincides with this cycle. Next state is IDLE.
- **Latency (defaults):**
  - Start is accepted at edge E0.
  - out_valid is high after edges E10, E20, E30 and E40 (10 cycles per pixel).
  - done is high after E40; busy falls at E41.
- **start handling:**
  - start in RUN, DRAIN or DONE is ignored.
  - start held high continuously restarts a run on the edge after DONE+IDLE, i.e. one IDLE cycle minimum.
- **Arithmetic:** unsigned only; no saturation needed given the ACC_W rule.
- **out_data/out_addr:** hold their last value until the next result or reset.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 immediately; with start=0 for 20 cycles, busy, mem_re and out_valid stay 0.
- All-ones image and filter, start pulse -> four out_valid strobes after E10/20/30/40 with out_addr 0,1,2,3 and out_data 9 each; done after E40.
- Maximum values, image=15 and filter=15 everywhere -> every out_data=2025, no overflow.
- Image img[i]=i (0..15), filter with only flt[4]=1 -> out_data 5,6,9,10 at out_addr 0..3. Check the img_addr sequence for pixel 0: 0,1,2,4,5,6,8,9,10.
- start re-asserted during RUN, plus start held high -> mid-run start has no effect on results or timing; held start gives a second identical run beginning after one IDLE cycle.
- rst_n asserted at E15 mid-run -> immediate IDLE, outputs 0, no further out_valid; a fresh start yields correct results from pixel 0.

Source files
------------

// File: rtl/conv_mac_if.sv
// conv_mac_if: control, memory-read, multiplier and result signals of the convolution sequencer
interface conv_mac_if #(
    parameter int IMG_W = 4,
    parameter int FLT_W = 3,
    parameter int DW    = 4,
    parameter int PW    = 8,
    parameter int ACC_W = 12
);
    localparam int OUT_W = IMG_W - FLT_W + 1;
    localparam int IAW   = $clog2(IMG_W * IMG_W);
    localparam int FAW   = $clog2(FLT_W * FLT_W);
    localparam int OAW   = $clog2(OUT_W * OUT_W);

    logic             start;
    logic             busy;
    logic             done;
    logic             mem_re;
    logic [IAW-1:0]   img_addr;
    logic [DW-1:0]    img_rdata;
    logic [FAW-1:0]   flt_addr;
    logic [DW-1:0]    flt_rdata;
    logic             mul_start;
    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic [PW-1:0]    mul_p;
    logic             out_valid;
    logic [OAW-1:0]   out_addr;
    logic [ACC_W-1:0] out_data;

    modport master (
        input  start, img_rdata, flt_rdata, mul_p,
        output busy, done, mem_re, img_addr, flt_addr, mul_start, mul_a, mul_b,
               out_valid, out_addr, out_data
    );

    modport slave (
        output start, img_rdata, flt_rdata, mul_p,
        input  busy, done, mem_re, img_addr, flt_addr, mul_start, mul_a, mul_b,
               out_valid, out_addr, out_data
    );
endinterface

// File: rtl/conv_mac_controller.sv
// conv_mac_controller: sequences one stride-1 convolution layer through a shared multiplier
module conv_mac_controller #(
    parameter int IMG_W = 4,
    parameter int FLT_W = 3,
    parameter int DW    = 4,
    parameter int PW    = 8,
    parameter int ACC_W = 12
) (
    input logic        clk,
    input logic        rst_n,
    conv_mac_if.master bus
);
    localparam int OUT_W = IMG_W - FLT_W + 1;
    localparam int IAW   = $clog2(IMG_W * IMG_W);
    localparam int FAW   = $clog2(FLT_W * FLT_W);
    localparam int OAW   = $clog2(OUT_W * OUT_W);
    localparam int TW    = $clog2(FLT_W + 1);
    localparam int RW    = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    tr, tc, tr_n, tc_n;
    logic [RW-1:0]    row, col, row_n, col_n;
    logic             vld;
    logic [ACC_W-1:0] acc, sum, out_data;
    logic [IAW-1:0]   img_addr, ia_n;
    logic [FAW-1:0]   flt_addr, fa_n;
    logic [OAW-1:0]   out_addr, oa;
    logic             out_valid;
    logic             last_tc, last_tap, last_col, last_pix;

    assign last_tc  = tc == TW'(FLT_W - 1);
    assign last_tap = last_tc && tr == TW'(FLT_W - 1);
    assign last_col = col == RW'(OUT_W - 1);
    assign last_pix = last_col && row == RW'(OUT_W - 1);
    assign sum      = acc + {{(ACC_W - PW){1'b0}}, bus.mul_p};
    assign ia_n     = IAW'((32'(row_n) + 32'(tr_n)) * IMG_W + 32'(col_n) + 32'(tc_n));
    assign fa_n     = FAW'(32'(tr_n) * FLT_W + 32'(tc_n));
    assign oa       = OAW'(32'(row) * OUT_W + 32'(col));

    // state and tap/pixel counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tr    <= '0;
            tc    <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            tr    <= tr_n;
            tc    <= tc_n;
            row   <= row_n;
            col   <= col_n;
        end
    end

    // next state; tap counter walks the filter row-major, pixel counter advances on DRAIN
    always_comb begin
        state_n = state;
        tr_n    = tr;
        tc_n    = tc;
        row_n   = row;
        col_n   = col;
        case (state)
            IDLE: begin
                state_n = bus.start ? RUN : IDLE;
                tr_n    = '0;
                tc_n    = '0;
                row_n   = '0;
                col_n   = '0;
            end
            RUN: begin
                state_n = last_tap ? DRAIN : RUN;
                tc_n    = last_tc ? '0 : tc + TW'(1);
                tr_n    = last_tc ? tr + TW'(1) : tr;
            end
            DRAIN: begin
                state_n = last_pix ? DONE : RUN;
                tr_n    = '0;
                tc_n    = '0;
                col_n   = last_col ? '0 : col + RW'(1);
                row_n   = last_pix ? '0 : (last_col ? row + RW'(1) : row);
            end
            default: begin
                state_n = IDLE;
                row_n   = '0;
                col_n   = '0;
            end
        endcase
    end

    // registered read addresses, one-cycle product valid, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_addr  <= '0;
            flt_addr  <= '0;
            vld       <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            img_addr  <= state_n == RUN ? ia_n : '0;
            flt_addr  <= state_n == RUN ? fa_n : '0;
            vld       <= state == RUN;
            acc       <= (state == RUN && vld) ? sum : '0;
            out_valid <= state == DRAIN;
            if (state == DRAIN) begin
                out_data <= sum;
                out_addr <= oa;
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.mem_re    = state == RUN;
    assign bus.img_addr  = img_addr;
    assign bus.flt_addr  = flt_addr;
    assign bus.mul_start = vld;
    assign bus.mul_a     = DW'(bus.img_rdata);
    assign bus.mul_b     = DW'(bus.flt_rdata);
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_conv_mac_controller.sv
// tb_conv_mac_controller: directed and randomized runs checked against a convolution reference model
module tb_conv_mac_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int checks   = 0;
    int failures = 0;
    logic [3:0] img [16];
    logic [3:0] flt [9];

    conv_mac_if bus ();

    conv_mac_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.img_rdata <= img[bus.img_addr];
            bus.flt_rdata <= flt[bus.flt_addr];
        end
    end

    assign bus.mul_p = bus.mul_start ? ({4'b0, bus.mul_a} * {4'b0, bus.mul_b}) : 8'd0;

    function automatic int ref_pix(input int p);
        int r = p / 2;
        int c = p % 2;
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[(r + i) * 4 + c + j]) * int'(flt[i * 3 + j]);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int mode);
        for (int i = 0; i < 16; i++)
            img[i] = mode == 0 ? 4'd1 : mode == 1 ? 4'd15 : mode == 2 ? 4'(i) : 4'($urandom_range(0, 15));
        for (int i = 0; i < 9; i++)
            flt[i] = mode == 0 ? 4'd1 : mode == 1 ? 4'd15 : mode == 2 ? 4'(i == 4) : 4'($urandom_range(0, 15));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.busy, bus.done, bus.mem_re, bus.mul_start, bus.out_valid,
                  bus.img_addr, bus.flt_addr, bus.out_addr, bus.out_data}, 32'd0);
    endtask

    task automatic run(input bit hold, input bit mid);
        logic [4:0] exp;
        int p, t;
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (!hold) bus.start = mid && k == 5;
            exp = {k <= 40, k == 40, k < 40 && k % 10 != 9, k < 40 && k % 10 != 0,
                   k >= 10 && k <= 40 && k % 10 == 0};
            chk("ctl", {bus.busy, bus.done, bus.mem_re, bus.mul_start, bus.out_valid}, 32'(exp));
            if (k < 40 && k % 10 != 9) begin
                p = k / 10;
                t = k % 10;
                chk("img_addr", 32'(bus.img_addr), (p / 2 + t / 3) * 4 + p % 2 + t % 3);
                chk("flt_addr", 32'(bus.flt_addr), t);
            end
            if (k >= 10 && k <= 40 && k % 10 == 0) begin
                chk("out_addr", 32'(bus.out_addr), k / 10 - 1);
                chk("out_data", 32'(bus.out_data), ref_pix(k / 10 - 1));
            end
            if (k == 41) chk("out_hold", 32'(bus.out_data), ref_pix(3));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        #12 rst_n = 1'b0;
        #1 chk_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle", {bus.busy, bus.mem_re, bus.out_valid}, 32'd0);
        end
        load(0);
        run(1'b0, 1'b0);
        load(1);
        run(1'b0, 1'b0);
        load(2);
        run(1'b0, 1'b0);
        load(3);
        run(1'b0, 1'b1);
        load(3);
        run(1'b1, 1'b0);
        run(1'b0, 1'b0);
        load(3);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_idle", {bus.busy, bus.mem_re, bus.out_valid}, 32'd0);
        end
        run(1'b0, 1'b0);
        repeat (2) begin
            load(3);
            run(1'b0, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
